// File: rtl/i2s_rx_deserializer_pkg.sv
// rtl/i2s_rx_deserializer_pkg.sv - shared widths, counter sizing and state encoding for the I2S receive path
package i2s_rx_deserializer_pkg;

   localparam int DATA_W   = 16;
   localparam int SLOT_MAX = 32;
   localparam int CNT_W    = $clog2(SLOT_MAX + 2);

   localparam logic [0:0] ST_SYNC = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [CNT_W-1:0]  count_t;

   // prior_bits excludes the bit sampled on the closing transition edge
   function automatic logic short_slot(input count_t prior_bits);
      return prior_bits < count_t'(DATA_W - 1);
   endfunction

endpackage

// File: rtl/i2s_shift_capture.sv
// rtl/i2s_shift_capture.sv - MSB-first slot capture with saturating bit counter
// word is look-ahead: it already contains this cycle's bit when shift_en is high
module i2s_shift_capture
   import i2s_rx_deserializer_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   shift_en,
   input  logic   clear,
   input  logic   data_bit,
   output word_t  word,
   output count_t count
);

   word_t  sreg;
   count_t pos;
   logic   take;

   assign take = shift_en && (count < count_t'(DATA_W));
   assign pos  = count_t'(DATA_W - 1) - count;

   // bits land at their final position, so a short slot is already left-justified
   always_comb begin
      word = sreg;
      if (take && data_bit) begin
         word = sreg | (word_t'(1) << pos);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sreg  <= '0;
         count <= '0;
      end else if (shift_en) begin
         sreg <= word;
         if (count != count_t'(SLOT_MAX + 1)) begin
            count <= count + count_t'(1);
         end
      end
   end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S receiver: LRCK lock FSM, slot publish and framing error tracking
module i2s_rx_deserializer
   import i2s_rx_deserializer_pkg::*;
(
   input  logic              AUD_BCLK,
   input  logic              RST,
   input  logic              AUD_ADCLRCK,
   input  logic              AUD_ADCDAT,
   output logic [DATA_W-1:0] AUD_L,
   output logic [DATA_W-1:0] AUD_R,
   output logic              VALID_L,
   output logic              VALID_R,
   output logic              LOCKED,
   output logic              FRAME_ERR
);

   logic [0:0] state;
   logic       lrck_q;
   logic       lrck_edge;
   logic       in_run;
   logic       overrun;
   logic       shift_en;
   logic       clear;
   word_t      cap_word;
   count_t     cap_count;

   assign lrck_edge = (lrck_q != AUD_ADCLRCK);
   assign in_run    = (state == ST_RUN);
   assign overrun   = in_run && !lrck_edge && (cap_count > count_t'(SLOT_MAX));
   assign shift_en  = in_run && !overrun;
   assign clear     = !in_run || lrck_edge || overrun;
   assign LOCKED    = in_run;

   i2s_shift_capture u_capture (
      .clk      (AUD_BCLK),
      .rst      (RST),
      .shift_en (shift_en),
      .clear    (clear),
      .data_bit (AUD_ADCDAT),
      .word     (cap_word),
      .count    (cap_count)
   );

   // lrck_q tracks the pin even in reset so the first edge after reset is never a transition
   always_ff @(posedge AUD_BCLK) begin
      lrck_q <= AUD_ADCLRCK;
      if (RST) begin
         state     <= ST_SYNC;
         AUD_L     <= '0;
         AUD_R     <= '0;
         VALID_L   <= 1'b0;
         VALID_R   <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         VALID_L <= 1'b0;
         VALID_R <= 1'b0;
         if (state == ST_SYNC) begin
            if (lrck_edge) begin
               state <= ST_RUN;
            end
         end else if (lrck_edge) begin
            if (lrck_q == 1'b0) begin
               AUD_L   <= cap_word;
               VALID_L <= 1'b1;
            end else begin
               AUD_R   <= cap_word;
               VALID_R <= 1'b1;
            end
            if (short_slot(cap_count)) begin
               FRAME_ERR <= 1'b1;
            end
         end else if (overrun) begin
            FRAME_ERR <= 1'b1;
            state     <= ST_SYNC;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - randomized self-checking bench against a slot-level model
module tb_i2s_rx_deserializer;
   import i2s_rx_deserializer_pkg::*;

   logic              AUD_BCLK = 1'b0;
   logic              RST = 1'b1;
   logic              AUD_ADCLRCK = 1'b0;
   logic              AUD_ADCDAT = 1'b0;
   logic [DATA_W-1:0] AUD_L;
   logic [DATA_W-1:0] AUD_R;
   logic              VALID_L;
   logic              VALID_R;
   logic              LOCKED;
   logic              FRAME_ERR;

   int checks = 0;
   int errors = 0;

   always #5 AUD_BCLK = ~AUD_BCLK;

   i2s_rx_deserializer dut (
      .AUD_BCLK    (AUD_BCLK),
      .RST         (RST),
      .AUD_ADCLRCK (AUD_ADCLRCK),
      .AUD_ADCDAT  (AUD_ADCDAT),
      .AUD_L       (AUD_L),
      .AUD_R       (AUD_R),
      .VALID_L     (VALID_L),
      .VALID_R     (VALID_R),
      .LOCKED      (LOCKED),
      .FRAME_ERR   (FRAME_ERR)
   );

   // slot list: slot 0 is whatever is in progress when the stream starts
   int          sl_lr[$];
   int          sl_n[$];
   logic [15:0] sl_w[$];
   bit          pad_zero;

   int          obs_cyc[$];
   int          obs_side[$];
   logic [15:0] obs_word[$];
   int          both_cnt;

   int          exp_cyc[$];
   int          exp_side[$];
   logic [15:0] exp_word[$];
   logic        exp_locked;
   logic        exp_err;

   task automatic clear_slots();
      sl_lr.delete(); sl_n.delete(); sl_w.delete();
   endtask

   task automatic add_slot(input int lr, input int n, input logic [15:0] w);
      sl_lr.push_back(lr); sl_n.push_back(n); sl_w.push_back(w);
   endtask

   task automatic do_reset(input logic lr);
      @(negedge AUD_BCLK);
      RST = 1'b1; AUD_ADCLRCK = lr; AUD_ADCDAT = 1'b0;
      repeat (2) @(posedge AUD_BCLK);
      #1;
   endtask

   // Slot-level reference: a slot opened by a transition while locked is published at the
   // first cycle of the following slot; it carries its first min(n,16) bits left-justified.
   task automatic model(input logic err_in);
      int          start;
      int          nb;
      bit          locked;
      logic [15:0] mask;
      exp_cyc.delete(); exp_side.delete(); exp_word.delete();
      locked = 0; exp_err = err_in; start = 0;
      for (int k = 0; k < sl_n.size(); k++) begin
         if (k > 0) begin
            if (locked) begin
               nb   = (sl_n[k-1] < DATA_W) ? sl_n[k-1] : DATA_W;
               mask = 16'hFFFF << (DATA_W - nb);
               exp_cyc.push_back(start);
               exp_side.push_back(sl_lr[k-1]);
               exp_word.push_back(sl_w[k-1] & mask);
               if (nb < DATA_W) exp_err = 1'b1;
            end
            locked = 1;
         end
         if (locked && sl_n[k] > SLOT_MAX + 2) begin
            locked  = 0;
            exp_err = 1'b1;
         end
         start += sl_n[k];
      end
      exp_locked = locked;
   endtask

   task automatic play();
      int   lq[$];
      logic dq[$];
      obs_cyc.delete(); obs_side.delete(); obs_word.delete();
      both_cnt = 0;
      dq.push_back(1'($urandom));
      for (int k = 0; k < sl_n.size(); k++) begin
         for (int j = 0; j < sl_n[k]; j++) begin
            lq.push_back(sl_lr[k]);
            if (j < DATA_W) dq.push_back(sl_w[k][15-j]);
            else            dq.push_back(pad_zero ? 1'b0 : 1'($urandom));
         end
      end
      for (int c = 0; c < lq.size(); c++) begin
         @(negedge AUD_BCLK);
         RST = 1'b0; AUD_ADCLRCK = lq[c][0]; AUD_ADCDAT = dq[c];
         @(posedge AUD_BCLK);
         #1;
         if (VALID_L && VALID_R) both_cnt++;
         if (VALID_L) begin obs_cyc.push_back(c); obs_side.push_back(0); obs_word.push_back(AUD_L); end
         if (VALID_R) begin obs_cyc.push_back(c); obs_side.push_back(1); obs_word.push_back(AUD_R); end
      end
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      checks++; if (AUD_L !== 16'h0)     begin errors++; $display("FAIL reset AUD_L: got %h want 0000", AUD_L); end
      checks++; if (AUD_R !== 16'h0)     begin errors++; $display("FAIL reset AUD_R: got %h want 0000", AUD_R); end
      checks++; if (VALID_L !== 1'b0 || VALID_R !== 1'b0) begin errors++; $display("FAIL reset VALID: got %b%b want 00", VALID_L, VALID_R); end
      checks++; if (LOCKED !== 1'b0)     begin errors++; $display("FAIL reset LOCKED: got %b want 0", LOCKED); end
      checks++; if (FRAME_ERR !== 1'b0)  begin errors++; $display("FAIL reset FRAME_ERR: got %b want 0", FRAME_ERR); end
      for (int i = 0; i < 3; i++) begin
         @(negedge AUD_BCLK); RST = 1'b0; AUD_ADCLRCK = 1'b1;
         @(posedge AUD_BCLK); #1;
         checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset no-edge LOCKED cycle %0d: got %b want 0", i, LOCKED); end
      end
      @(negedge AUD_BCLK); AUD_ADCLRCK = 1'b0;
      @(posedge AUD_BCLK); #1;
      checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL reset first-edge LOCKED: got %b want 1", LOCKED); end
   endtask

   task automatic test_32bit_slots();
      clear_slots(); pad_zero = 1;
      add_slot(1, 3, 16'($urandom));
      add_slot(0, 32, 16'h8001); add_slot(1, 32, 16'h7FFE);
      add_slot(0, 32, 16'h8001); add_slot(1, 32, 16'h7FFE);
      add_slot(0, 2, 16'h0);
      do_reset(1'b1); play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL s32 pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL s32 word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
      checks++; if (AUD_L !== 16'h8001 || AUD_R !== 16'h7FFE) begin errors++; $display("FAIL s32 held words: got %h/%h want 8001/7ffe", AUD_L, AUD_R); end
      checks++; if (LOCKED !== 1'b1 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL s32 flags: got %b%b want 10", LOCKED, FRAME_ERR); end
   endtask

   task automatic test_16bit_slots();
      clear_slots(); pad_zero = 0;
      add_slot(1, 5, 16'($urandom));
      add_slot(0, 16, 16'hA5C3); add_slot(1, 16, 16'h0001);
      add_slot(0, 16, 16'hA5C3); add_slot(1, 16, 16'h0001);
      add_slot(0, 16, 16'hA5C3); add_slot(1, 4, 16'($urandom));
      do_reset(1'b1); play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL s16 pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL s16 word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
      checks++; if (AUD_L !== 16'hA5C3 || AUD_R !== 16'h0001) begin errors++; $display("FAIL s16 held words: got %h/%h want a5c3/0001", AUD_L, AUD_R); end
      checks++; if (LOCKED !== 1'b1 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL s16 flags: got %b%b want 10", LOCKED, FRAME_ERR); end
   endtask

   task automatic test_short_slot();
      clear_slots(); pad_zero = 0;
      add_slot(1, 3, 16'($urandom));
      add_slot(0, 32, 16'h1234); add_slot(1, 10, 16'hFFC0);
      add_slot(0, 32, 16'($urandom)); add_slot(1, 24, 16'($urandom));
      add_slot(0, 4, 16'($urandom));
      do_reset(1'b1); play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL short pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL short word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
      checks++; if (obs_word.size() < 2 || obs_word[1] !== 16'hFFC0) begin errors++; $display("FAIL short AUD_R value: got %0d words want second = ffc0", obs_word.size()); end
      checks++; if (LOCKED !== 1'b1 || FRAME_ERR !== 1'b1) begin errors++; $display("FAIL short flags: got %b%b want 11", LOCKED, FRAME_ERR); end
   endtask

   task automatic test_overrun();
      clear_slots(); pad_zero = 0;
      add_slot(1, 3, 16'($urandom));
      add_slot(0, 32, 16'($urandom)); add_slot(1, 32, 16'($urandom));
      add_slot(0, 24, 16'($urandom)); add_slot(1, 40, 16'($urandom));
      do_reset(1'b1); play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL ovr pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL ovr word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
      checks++; if (LOCKED !== 1'b0 || FRAME_ERR !== 1'b1) begin errors++; $display("FAIL ovr flags: got %b%b want 01", LOCKED, FRAME_ERR); end
      // resume without reset: the held-high LRCK continues as an unlocked partial slot
      clear_slots();
      add_slot(1, 2, 16'($urandom));
      add_slot(0, 32, 16'h4C1D); add_slot(1, 32, 16'hB00F);
      add_slot(0, 3, 16'($urandom));
      play(); model(1'b1);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL ovr resume pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL ovr resume word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
      checks++; if (LOCKED !== 1'b1 || FRAME_ERR !== 1'b1) begin errors++; $display("FAIL ovr resume flags: got %b%b want 11", LOCKED, FRAME_ERR); end
   endtask

   task automatic test_reset_mid_slot();
      clear_slots(); pad_zero = 0;
      add_slot(1, 5, 16'($urandom));
      add_slot(0, 32, 16'($urandom)); add_slot(1, 32, 16'($urandom));
      add_slot(0, 8, 16'($urandom));
      do_reset(1'b1); play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL midrst pre pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      do_reset(1'b0);
      checks++; if (VALID_L !== 1'b0 || VALID_R !== 1'b0) begin errors++; $display("FAIL midrst VALID: got %b%b want 00", VALID_L, VALID_R); end
      checks++; if (AUD_L !== 16'h0 || AUD_R !== 16'h0) begin errors++; $display("FAIL midrst words: got %h/%h want 0000/0000", AUD_L, AUD_R); end
      checks++; if (LOCKED !== 1'b0 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL midrst flags: got %b%b want 00", LOCKED, FRAME_ERR); end
      clear_slots();
      add_slot(0, 20, 16'($urandom));
      add_slot(1, 32, 16'($urandom)); add_slot(0, 32, 16'($urandom));
      add_slot(1, 5, 16'($urandom));
      play(); model(1'b0);
      checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL midrst post pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
            errors++; $display("FAIL midrst word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lr;
      for (int rep = 0; rep < 3; rep++) begin
         clear_slots(); pad_zero = 0;
         add_slot(1, $urandom_range(1, 10), 16'($urandom));
         lr = 0;
         for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 3) == 0) add_slot(lr, $urandom_range(2, 15), 16'($urandom));
            else                           add_slot(lr, $urandom_range(16, 32), 16'($urandom));
            lr = 1 - lr;
         end
         add_slot(lr, 3, 16'($urandom));
         do_reset(1'b1); play(); model(1'b0);
         checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL rand%0d pulses: got %0d want %0d", rep, obs_cyc.size(), exp_cyc.size()); end
         for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_side[i] !== exp_side[i] || obs_word[i] !== exp_word[i]) begin
               errors++; $display("FAIL rand%0d word %0d: got cyc %0d side %0d %h want cyc %0d side %0d %h", rep, i, obs_cyc[i], obs_side[i], obs_word[i], exp_cyc[i], exp_side[i], exp_word[i]);
            end
         end
         checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rand%0d dual VALID: got %0d cycles want 0", rep, both_cnt); end
         checks++; if (LOCKED !== exp_locked || FRAME_ERR !== exp_err) begin errors++; $display("FAIL rand%0d flags: got %b%b want %b%b", rep, LOCKED, FRAME_ERR, exp_locked, exp_err); end
      end
   endtask

   initial begin
      test_reset();
      test_32bit_slots();
      test_16bit_slots();
      test_short_slot();
      test_overrun();
      test_reset_mid_slot();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
